// File: rtl/seg_timer_mux.sv
// N-digit BCD up/down timer with start/stop/clear pads and a scanned 7-segment driver.
// Optional build macro BLANK_LEADING_ZERO_EN suppresses leading zero digits (digit 0 always shown).

module seg_timer_digit (
  input  logic       clk,
  input  logic [3:0] nib,
  input  logic       dn,
  input  logic       cin,
  output logic [3:0] nxt,
  output logic       cout
);
  // clk is unused; it keeps the per-digit cell interface uniform for retiming later
  logic unused_clk;
  assign unused_clk = clk;

  always_comb begin
    nxt  = nib;
    cout = 1'b0;
    if (cin) begin
      if (!dn) begin
        if (nib >= 4'd9) begin
          nxt  = 4'd0;
          cout = 1'b1;
        end else begin
          nxt = nib + 4'd1;
        end
      end else begin
        if (nib == 4'd0) begin
          nxt  = 4'd9;
          cout = 1'b1;
        end else begin
          nxt = nib - 4'd1;
        end
      end
    end
  end
endmodule

module seg_timer_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 1000000,
  parameter int SCAN_DIV   = 10000,
  parameter int DP_DIGIT   = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  clear_i,
  input  logic                  dir_i,
  output logic [7:0]            seven_seg,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  running_o,
  output logic                  wrap_o
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef struct packed {
    logic clear;
    logic stop;
    logic start;
  } ctrl_t;

  logic [3:0] sync1, sync2;
  logic [2:0] edge_d;
  ctrl_t      ev;
  logic       dir_s;

  logic [PW-1:0] pre;
  logic          tick;

  logic [NUM_DIGITS-1:0][3:0] cnt, cnt_nxt;
  logic [NUM_DIGITS:0]        carry;

  logic [SW-1:0]         scan;
  logic [IW-1:0]         idx;
  logic                  scan_end;
  logic [3:0]            cur;
  logic [6:0]            segs;
  logic [NUM_DIGITS-1:0] en_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Pads: 2-FF sync, then edge detect against the previous synced value
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1  <= '0;
      sync2  <= '0;
      edge_d <= '0;
    end else begin
      sync1  <= {dir_i, clear_i, stop_i, start_i};
      sync2  <= sync1;
      edge_d <= sync2[2:0];
    end
  end

  assign ev    = sync2[2:0] & ~edge_d;
  assign dir_s = sync2[3];
  assign tick  = running_o && (pre == PW'(TICK_DIV - 1));

  assign carry[0] = 1'b1;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    seg_timer_digit u_dig (
      .clk  (wb_clk_i),
      .nib  (cnt[g]),
      .dn   (dir_s),
      .cin  (carry[g]),
      .nxt  (cnt_nxt[g]),
      .cout (carry[g+1])
    );
  end

  // clear beats stop beats start; a clear still lets a coincident start through
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      running_o <= 1'b0;
      wrap_o    <= 1'b0;
      pre       <= '0;
      cnt       <= '0;
    end else begin
      wrap_o <= 1'b0;
      if (ev.stop)       running_o <= 1'b0;
      else if (ev.start) running_o <= 1'b1;

      if (ev.clear || ev.stop) pre <= '0;
      else if (running_o)      pre <= tick ? '0 : pre + 1'b1;

      if (ev.clear) begin
        cnt <= '0;
      end else if (tick && !ev.stop) begin
        cnt    <= cnt_nxt;
        wrap_o <= carry[NUM_DIGITS];
      end
    end
  end

  assign scan_end = (scan == SW'(SCAN_DIV - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      scan <= '0;
      idx  <= '0;
    end else begin
      scan <= scan_end ? '0 : scan + 1'b1;
      if (scan_end) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

`ifdef BLANK_LEADING_ZERO_EN
  logic [NUM_DIGITS-1:0] blank;
  logic                  lead;

  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lead     = lead && (cnt[i] == 4'd0);
      blank[i] = lead;
    end
  end
`endif

  always_comb begin
    en_nxt      = '0;
    en_nxt[idx] = 1'b1;
    cur         = cnt[idx];
`ifdef BLANK_LEADING_ZERO_EN
    segs = blank[idx] ? 7'h00 : seg7(cur);
`else
    segs = seg7(cur);
`endif
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      digit_en  <= NUM_DIGITS'(1);
      seven_seg <= {(DP_DIGIT == 0), 7'h3F};
    end else begin
      digit_en  <= en_nxt;
      seven_seg <= {(int'(idx) == DP_DIGIT), segs};
    end
  end
endmodule

// File: tb/tb_seg_timer_mux.sv
// Scoreboard bench for seg_timer_mux (2 digits, tick every 4 clocks, scan every 3).
// Expected status/display words are queued per scenario and popped cycle by cycle.

module tb_seg_timer_mux;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0, stop_i = 1'b0, clear_i = 1'b0, dir_i = 1'b0;
  logic [7:0] seven_seg;
  logic [1:0] digit_en;
  logic       running_o, wrap_o;
  logic [7:0] cnt_obs;

  logic [9:0] sb[$];
  logic [9:0] dq[$];
  logic [9:0] exp_v, obs_v;
  int         n_vec = 0;
  int         n_err = 0;

  seg_timer_mux #(.NUM_DIGITS(2), .TICK_DIV(4), .SCAN_DIV(3), .DP_DIGIT(1)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .clear_i   (clear_i),
    .dir_i     (dir_i),
    .seven_seg (seven_seg),
    .digit_en  (digit_en),
    .running_o (running_o),
    .wrap_o    (wrap_o)
  );

  assign cnt_obs = dut.cnt;

  always #5 clk = ~clk;

  function automatic logic [9:0] st(input int v, input logic run, input logic wrp);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo, run, wrp};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    sb.push_back(st(0, 1'b0, 1'b0));
    dq.push_back({2'b01, 8'h3F});
    exp_v = sb.pop_front(); obs_v = {cnt_obs, running_o, wrap_o}; n_vec++;
    if (obs_v !== exp_v) begin
      n_err++;
      $display("FAIL reset_status: got cnt=%h run=%b wrap=%b, want cnt=%h run=%b wrap=%b",
               obs_v[9:2], obs_v[1], obs_v[0], exp_v[9:2], exp_v[1], exp_v[0]);
    end
    exp_v = dq.pop_front(); obs_v = {digit_en, seven_seg}; n_vec++;
    if (obs_v !== exp_v) begin
      n_err++;
      $display("FAIL reset_display: got en=%b seg=%h, want en=%b seg=%h",
               obs_v[9:8], obs_v[7:0], exp_v[9:8], exp_v[7:0]);
    end
  endtask

  task automatic test_idle;
    for (int i = 0; i < 20; i++) begin
      sb.push_back(st(0, 1'b0, 1'b0));
      dq.push_back(((i / 3) % 2 == 1) ? {2'b10, 8'hBF} : {2'b01, 8'h3F});
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      exp_v = sb.pop_front(); obs_v = {cnt_obs, running_o, wrap_o}; n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL idle_status cyc %0d: got %h want %h", i, obs_v, exp_v);
      end
      exp_v = dq.pop_front(); obs_v = {digit_en, seven_seg}; n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL idle_scan cyc %0d: got en=%b seg=%h, want en=%b seg=%h",
                 i, obs_v[9:8], obs_v[7:0], exp_v[9:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_start_up;
    for (int i = 0; i < 46; i++)
      sb.push_back(st((i >= 6) ? (i - 6) / 4 + 1 : 0, i >= 2, 1'b0));
    dir_i = 1'b0; start_i = 1'b1;
    for (int i = 0; i < 46; i++) begin
      @(negedge clk);
      if (i == 0) start_i = 1'b0;
      exp_v = sb.pop_front(); obs_v = {cnt_obs, running_o, wrap_o}; n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL start_up cyc %0d: got cnt=%h run=%b wrap=%b, want cnt=%h run=%b wrap=%b",
                 i, obs_v[9:2], obs_v[1], obs_v[0], exp_v[9:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_wrap_up;
    for (int m = 0; m < 360; m++)
      sb.push_back(st((11 + m / 4) % 100, 1'b1, m == 356));
    for (int m = 0; m < 360; m++) begin
      @(negedge clk);
      exp_v = sb.pop_front(); obs_v = {cnt_obs, running_o, wrap_o}; n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL wrap_up cyc %0d: got cnt=%h run=%b wrap=%b, want cnt=%h run=%b wrap=%b",
                 m, obs_v[9:2], obs_v[1], obs_v[0], exp_v[9:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  // dir flips just before a tick edge: that tick still counts up, the next one counts down
  task automatic test_down;
    for (int m = 0; m < 372; m++)
      sb.push_back(st((m < 4) ? 1 : (m < 8) ? 0 : 99 - (m - 8) / 4, 1'b1, m == 8));
    dir_i = 1'b1;
    for (int m = 0; m < 372; m++) begin
      @(negedge clk);
      exp_v = sb.pop_front(); obs_v = {cnt_obs, running_o, wrap_o}; n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL down cyc %0d: got cnt=%h run=%b wrap=%b, want cnt=%h run=%b wrap=%b",
                 m, obs_v[9:2], obs_v[1], obs_v[0], exp_v[9:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_same_cycle;
    int v;
    logic r;
    for (int n = 0; n < 196; n++) begin
      if (n < 2)        v = 8;
      else if (n < 173) v = (n - 2) / 4;
      else if (n < 183) v = 42;
      else              v = 0;
      r = (n < 173) || (n >= 183 && n < 186);
      sb.push_back(st(v, r, 1'b0));
    end
    dir_i = 1'b0; clear_i = 1'b1;
    for (int n = 0; n < 196; n++) begin
      @(negedge clk);
      start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0;
      exp_v = sb.pop_front(); obs_v = {cnt_obs, running_o, wrap_o}; n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL same_cycle cyc %0d: got cnt=%h run=%b wrap=%b, want cnt=%h run=%b wrap=%b",
                 n, obs_v[9:2], obs_v[1], obs_v[0], exp_v[9:2], exp_v[1], exp_v[0]);
      end
      if (n == 170) stop_i = 1'b1;
      if (n == 180) begin clear_i = 1'b1; start_i = 1'b1; end
      if (n == 183) begin stop_i = 1'b1; start_i = 1'b1; end
    end
  endtask

  task automatic test_clear_on_tick;
    for (int n = 0; n < 16; n++)
      sb.push_back(st((n < 10) ? 0 : (n < 14) ? 99 : 98, n >= 2, n == 10));
    dir_i = 1'b1; start_i = 1'b1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      start_i = 1'b0; clear_i = 1'b0;
      exp_v = sb.pop_front(); obs_v = {cnt_obs, running_o, wrap_o}; n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL clear_on_tick cyc %0d: got cnt=%h run=%b wrap=%b, want cnt=%h run=%b wrap=%b",
                 n, obs_v[9:2], obs_v[1], obs_v[0], exp_v[9:2], exp_v[1], exp_v[0]);
      end
      if (n == 3) clear_i = 1'b1;
    end
  endtask

  task automatic test_reset_mid;
    sb.push_back(st(0, 1'b0, 1'b0));
    dq.push_back({2'b01, 8'h3F});
    for (int n = 0; n < 12; n++) sb.push_back(st(0, 1'b0, 1'b0));
    rst = 1'b1;
    #1;
    exp_v = sb.pop_front(); obs_v = {cnt_obs, running_o, wrap_o}; n_vec++;
    if (obs_v !== exp_v) begin
      n_err++;
      $display("FAIL reset_mid_status: got %h want %h", obs_v, exp_v);
    end
    exp_v = dq.pop_front(); obs_v = {digit_en, seven_seg}; n_vec++;
    if (obs_v !== exp_v) begin
      n_err++;
      $display("FAIL reset_mid_display: got %h want %h", obs_v, exp_v);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; dir_i = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      exp_v = sb.pop_front(); obs_v = {cnt_obs, running_o, wrap_o}; n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid_idle cyc %0d: got %h want %h", n, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_blank;
    bit found;
    for (int n = 0; n < 28; n++)
      sb.push_back(st((n < 2) ? 0 : (n >= 22) ? 5 : (n - 2) / 4, n >= 2 && n < 25, 1'b0));
`ifdef BLANK_LEADING_ZERO_EN
    dq.push_back({2'b10, 8'h80});
`else
    dq.push_back({2'b10, 8'hBF});
`endif
    dq.push_back({2'b01, 8'h6D});
    dir_i = 1'b0; clear_i = 1'b1; start_i = 1'b1;
    for (int n = 0; n < 28; n++) begin
      @(negedge clk);
      start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0;
      exp_v = sb.pop_front(); obs_v = {cnt_obs, running_o, wrap_o}; n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL blank_count cyc %0d: got %h want %h", n, obs_v, exp_v);
      end
      if (n == 22) stop_i = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      exp_v = dq.pop_front();
      found = 1'b0;
      for (int t = 0; t < 12 && !found; t++) begin
        @(negedge clk);
        if (digit_en == exp_v[9:8]) found = 1'b1;
      end
      obs_v = {digit_en, seven_seg}; n_vec++;
      if (!found || obs_v !== exp_v) begin
        n_err++;
        $display("FAIL blank_digit%0d: got en=%b seg=%h, want en=%b seg=%h",
                 1 - k, obs_v[9:8], obs_v[7:0], exp_v[9:8], exp_v[7:0]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_idle;
    test_start_up;
    test_wrap_up;
    test_down;
    test_same_cycle;
    test_clear_on_tick;
    test_reset_mid;
    test_blank;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1);
  end
endmodule
